fft_frame_sched: RTL and testbench
==================================

# fft_frame_sched

Frame scheduler placed in front of the 256-point radix-2 FFT core. Accepts sample beats from an upstream valid/ready source and forwards only complete, gapless 256-sample frames to the core, since the core's input shift buffer advances every clock. It latches the per-frame inverse flag, tracks the frame through core latency and output drain, and reports framing errors. Downstream consumers see a clean sample stream with sop, eop and index.

## Interface
- N, 256: samples per frame; power of two.
- IDX_W, 8: log2(N).
- WDOG_CYC, 64: maximum number of WAIT cycles before core_sop_out must arrive. Used only with the watchdog.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid / s_ready / s_sop  in/out/in  1 each  upstream beat handshake; s_sop marks sample 0.
- s_inv  in  1  inverse-transform flag, sampled with s_sop.
- s_re, s_im  in  16 each  signed sample.
- core_valid, core_sop, core_inv  out  1 each  to the core's valid_in, sop_in and inv.
- core_re, core_im  out  16 each  to the core's x_re and x_im.
- core_valid_out, core_sop_out  in  1 each  from the core.
- m_valid, m_sop, m_eop  out  1 each  output stream qualifiers.
- m_idx  out  IDX_W  output sample index, 0..N-1.
- busy  out  1  high whenever the state is not IDLE.
- err  out  4  single-cycle pulses, {timeout, spurious, gap, restart}.
- frames_done  out  16  count of completed frames; wraps.

## Operation
- States: IDLE, LOAD, WAIT, DRAIN.
- A beat is accepted when s_valid and s_ready are both high. s_ready is 1 in IDLE and LOAD, 0 in WAIT and DRAIN.
- **IDLE**
  - Accepted beat with s_sop: latch s_inv into core_inv, set cnt=1, go to LOAD.
  - Accepted beat without s_sop: beat is discarded, no state change.
- **LOAD**
  - Each accepted beat increments cnt.
  - Beat N-1 accepted (cnt reaches N): go to WAIT.
  - s_valid low: abort the frame, pulse err[1] (gap), go to IDLE.
  - Accepted beat with s_sop: pulse err[0] (restart), relatch s_inv, set cnt=1, stay in LOAD. The core sees a new sop.
- **WAIT**
  - core_sop_out: go to DRAIN, set oidx=0.
  - With the watchdog enabled, wcnt reaches WDOG_CYC: pulse err[3] (timeout), go to IDLE.
- **DRAIN**
  - m_valid=core_valid_out, m_idx=oidx, m_sop=(oidx==0), m_eop=(oidx==N-1).
  - oidx increments on each m_valid.
  - After the eop beat: increment frames_done, go to IDLE.
- core_sop_out seen in IDLE, LOAD or DRAIN (oidx≠0): pulse err[2] (spurious) and ignore it.
- core_inv is held constant from latch until DRAIN exits, because the core applies inv on its output.
- Simultaneous events:
  - Gap and restart cannot coincide, since restart requires s_valid.
  - Timeout and core_sop_out in the same cycle: core_sop_out wins.

## Timing
- core_re, core_im, core_valid and core_sop are registered copies of accepted beats: 1-cycle latency, no gaps within a frame.
- An aborted frame stops core_valid the cycle after the gap.
- err bits are 1-cycle pulses registered on the cycle following the causing event.
- m_* outputs are combinational from core_valid_out and oidx; they add no latency over the core.
- Back-to-back frames: a new s_sop is accepted in the cycle after the DRAIN eop.
- Reset values: all outputs 0, including s_ready. State is IDLE; cnt, oidx, wcnt and frames_done are 0. s_ready rises to 1 on the first clock after reset release.
- Reset asserted mid-operation clears everything asynchronously. The partial frame is lost; there is no err pulse.

## Configuration
- FFT_SCHED_WDOG_EN
  - Defined: the WAIT watchdog (wcnt, err[3]) is present.
  - Undefined: WAIT waits forever for core_sop_out, and err[3] is tied to 0.

## Structure
- Shared package fft_pkg holds:
  - state enum type fft_sched_state_t;
  - FFT_N and FFT_IDX_W constants;
  - err bit-position constants ERR_RESTART=0, ERR_GAP=1, ERR_SPUR=2, ERR_TMO=3.
- One sub-module, fft_sched_cnt: a loadable up-counter with terminal-count flag. It is instantiated for cnt, oidx and wcnt.

## Test plan
- Clean frame with inv=0: 256 gapless beats. Required: core_valid has 256 cycles with core_sop on the first. With a core_sop_out stub 10 cycles later, m_idx runs 0..255 with m_eop at 255 and frames_done=1.
- Gap: s_valid low at sample 100. Required: err[1] pulses, core_valid stops after sample 99, state returns to IDLE.
- Restart: s_sop reasserted at sample 50 with s_inv=1. Required: err[0] pulses, core_inv=1, and the next 256 beats complete a frame normally.
- Timeout (FFT_SCHED_WDOG_EN defined): core_sop_out is withheld. Required: err[3] pulses exactly 64 cycles after WAIT entry, then busy=0.
- Spurious and reset: core_sop_out in IDLE pulses err[2]. rst_n asserted at LOAD sample 128 zeroes all outputs immediately. A fresh frame after release completes with frames_done=1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared scheduler types and constants: state encoding, frame geometry and err bit positions.
package fft_pkg;
  localparam int FFT_N     = 256;
  localparam int FFT_IDX_W = 8;

  localparam int ERR_RESTART = 0;
  localparam int ERR_GAP     = 1;
  localparam int ERR_SPUR    = 2;
  localparam int ERR_TMO     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fft_sched_state_t;
endpackage

// File: rtl/fft_sched_cnt.sv
// Loadable up-counter with terminal-count flag; load wins over increment, wraps at 2**W.
// One-cycle update latency, tc is combinational from the registered count.
module fft_sched_cnt #(
  parameter int W  = 8,
  parameter int TC = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == W'(TC));
endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler in front of the FFT core: passes only complete gapless frames, tracks drain, flags errors.
// core_* lag accepted beats by one cycle; m_* are combinational; s_ready drops in WAIT/DRAIN; watchdog under FFT_SCHED_WDOG_EN.
module fft_frame_sched
  import fft_pkg::*;
#(
  parameter int N        = FFT_N,
  parameter int IDX_W    = FFT_IDX_W,
  parameter int WDOG_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_sop,
  input  logic               s_inv,
  input  logic signed [15:0] s_re,
  input  logic signed [15:0] s_im,
  output logic               core_valid,
  output logic               core_sop,
  output logic               core_inv,
  output logic signed [15:0] core_re,
  output logic signed [15:0] core_im,
  input  logic               core_valid_out,
  input  logic               core_sop_out,
  output logic               m_valid,
  output logic               m_sop,
  output logic               m_eop,
  output logic [IDX_W-1:0]   m_idx,
  output logic               busy,
  output logic [3:0]         err,
  output logic [15:0]        frames_done
);
  fft_sched_state_t   state_q, state_d;
  logic               s_ready_q, s_ready_d;
  logic               core_valid_q, core_valid_d;
  logic               core_sop_q, core_sop_d;
  logic               core_inv_q, core_inv_d;
  logic signed [15:0] core_re_q, core_re_d;
  logic signed [15:0] core_im_q, core_im_d;
  logic [3:0]         err_q, err_d;
  logic [15:0]        frames_done_q, frames_done_d;

  logic               acc, fwd;
  logic               cnt_ld, cnt_inc, cnt_tc;
  logic               oidx_ld, oidx_tc, wdog_tc;
  logic [IDX_W-1:0]   oidx, load_cnt_unused;

  assign acc = s_valid && s_ready_q;

  fft_sched_cnt #(.W(IDX_W), .TC(N - 1)) u_cnt (
    .clk(clk), .rst_n(rst_n), .ld(cnt_ld), .ld_val(IDX_W'(1)), .inc(cnt_inc),
    .cnt(load_cnt_unused), .tc(cnt_tc)
  );

  fft_sched_cnt #(.W(IDX_W), .TC(N - 1)) u_oidx (
    .clk(clk), .rst_n(rst_n), .ld(oidx_ld), .ld_val('0), .inc(m_valid),
    .cnt(oidx), .tc(oidx_tc)
  );

`ifdef FFT_SCHED_WDOG_EN
  localparam int WCNT_W = $clog2(WDOG_CYC + 1);
  logic [WCNT_W-1:0] wcnt_unused;

  // Held at zero outside WAIT, so in WAIT it equals the number of cycles already spent there.
  fft_sched_cnt #(.W(WCNT_W), .TC(WDOG_CYC - 1)) u_wcnt (
    .clk(clk), .rst_n(rst_n), .ld(state_q != WAIT), .ld_val('0), .inc(state_q == WAIT),
    .cnt(wcnt_unused), .tc(wdog_tc)
  );
`else
  assign wdog_tc = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    err_d         = '0;
    core_inv_d    = core_inv_q;
    frames_done_d = frames_done_q;
    fwd           = 1'b0;
    cnt_ld        = 1'b0;
    cnt_inc       = 1'b0;
    oidx_ld       = 1'b0;

    case (state_q)
      IDLE: begin
        if (acc && s_sop) begin
          core_inv_d = s_inv;
          cnt_ld     = 1'b1;
          fwd        = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (!acc) begin
          err_d[ERR_GAP] = 1'b1;
          state_d        = IDLE;
        end else begin
          fwd = 1'b1;
          if (s_sop) begin
            err_d[ERR_RESTART] = 1'b1;
            core_inv_d         = s_inv;
            cnt_ld             = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            if (cnt_tc) begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (core_sop_out) begin
          oidx_ld = 1'b1;
          state_d = DRAIN;
        end else if (wdog_tc) begin
          err_d[ERR_TMO] = 1'b1;
          state_d        = IDLE;
        end
      end
      DRAIN: begin
        if (m_valid && oidx_tc) begin
          frames_done_d = frames_done_q + 16'd1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A core sop is legitimate only while awaiting the frame or still at its first output beat.
    if (core_sop_out && (state_q == IDLE || state_q == LOAD ||
                         (state_q == DRAIN && oidx != '0))) begin
      err_d[ERR_SPUR] = 1'b1;
    end

    s_ready_d    = (state_d == IDLE) || (state_d == LOAD);
    core_valid_d = fwd;
    core_sop_d   = fwd && s_sop;
    core_re_d    = fwd ? s_re : core_re_q;
    core_im_d    = fwd ? s_im : core_im_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      s_ready_q     <= 1'b0;
      core_valid_q  <= 1'b0;
      core_sop_q    <= 1'b0;
      core_inv_q    <= 1'b0;
      core_re_q     <= '0;
      core_im_q     <= '0;
      err_q         <= '0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      s_ready_q     <= s_ready_d;
      core_valid_q  <= core_valid_d;
      core_sop_q    <= core_sop_d;
      core_inv_q    <= core_inv_d;
      core_re_q     <= core_re_d;
      core_im_q     <= core_im_d;
      err_q         <= err_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign core_valid  = core_valid_q;
  assign core_sop    = core_sop_q;
  assign core_inv    = core_inv_q;
  assign core_re     = core_re_q;
  assign core_im     = core_im_q;
  assign err         = err_q;
  assign frames_done = frames_done_q;
  assign busy        = (state_q != IDLE);

  assign m_valid = (state_q == DRAIN) && core_valid_out;
  assign m_idx   = oidx;
  assign m_sop   = m_valid && (oidx == '0);
  assign m_eop   = m_valid && oidx_tc;
endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: clean, gap, restart, spurious, watchdog/no-watchdog and reset scenarios.
module tb_fft_frame_sched;
  import fft_pkg::*;

  localparam int N = 256;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_valid, s_ready, s_sop, s_inv;
  logic signed [15:0] s_re, s_im;
  logic               core_valid, core_sop, core_inv;
  logic signed [15:0] core_re, core_im;
  logic               core_valid_out, core_sop_out;
  logic               m_valid, m_sop, m_eop;
  logic [7:0]         m_idx;
  logic               busy;
  logic [3:0]         err;
  logic [15:0]        frames_done;

  int n_chk = 0;
  int n_err = 0;

  // Monitor state, written only by the monitor process.
  logic               mon_clr = 1'b0;
  int                 core_beats, core_sops, sop_beat;
  logic signed [15:0] last_re;
  int                 m_beats, m_sops, m_eops, eop_idx, exp_idx, idx_errs;
  int                 err_cnt [4];

  always #5 clk = ~clk;

  fft_frame_sched dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_sop(s_sop), .s_inv(s_inv),
    .s_re(s_re), .s_im(s_im),
    .core_valid(core_valid), .core_sop(core_sop), .core_inv(core_inv),
    .core_re(core_re), .core_im(core_im),
    .core_valid_out(core_valid_out), .core_sop_out(core_sop_out),
    .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_idx(m_idx),
    .busy(busy), .err(err), .frames_done(frames_done)
  );

  always @(negedge clk) begin
    if (mon_clr) begin
      core_beats = 0; core_sops = 0; sop_beat = -1; last_re = '0;
      m_beats = 0; m_sops = 0; m_eops = 0; eop_idx = -1; exp_idx = 0; idx_errs = 0;
      for (int b = 0; b < 4; b++) err_cnt[b] = 0;
    end else begin
      if (core_valid) begin
        if (core_sop) begin
          core_sops++;
          sop_beat = core_beats;
        end
        core_beats++;
        last_re = core_re;
      end
      if (m_valid) begin
        if (int'(m_idx) != exp_idx % N) idx_errs++;
        if (m_sop) m_sops++;
        if (m_eop) begin
          m_eops++;
          eop_idx = int'(m_idx);
        end
        m_beats++;
        exp_idx++;
      end
      for (int b = 0; b < 4; b++) err_cnt[b] += int'(err[b]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic send_beats(input int first, input int count, input bit sop, input bit inv);
    for (int i = 0; i < count; i++) begin
      s_valid = 1'b1;
      s_sop   = sop && (i == 0);
      s_inv   = inv;
      s_re    = 16'(first + i);
      s_im    = 16'(-(first + i));
      tick();
    end
    s_valid = 1'b0;
    s_sop   = 1'b0;
  endtask

  // Core stub: a lone sop pulse after `delay` cycles, then N output beats.
  task automatic core_out(input int delay);
    repeat (delay) tick();
    core_sop_out = 1'b1;
    tick();
    core_sop_out   = 1'b0;
    core_valid_out = 1'b1;
    repeat (N) tick();
    core_valid_out = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    s_valid = 0; s_sop = 0; s_inv = 0; s_re = '0; s_im = '0;
    core_valid_out = 0; core_sop_out = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_valid", core_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_frames", frames_done, 0);
    rst_n = 1'b1;
    chk("rel_s_ready_pre", s_ready, 0);
    tick();
    chk("rel_s_ready_post", s_ready, 1);

    // Clean frame, inv=0
    clr_mon();
    send_beats(0, N, 1, 0);
    chk("clean_wait_s_ready", s_ready, 0);
    chk("clean_wait_busy", busy, 1);
    core_out(10);
    chk("clean_core_beats", core_beats, 256);
    chk("clean_core_sops", core_sops, 1);
    chk("clean_sop_beat", sop_beat, 0);
    chk("clean_last_re", 32'(last_re), 255);
    chk("clean_core_inv", core_inv, 0);
    chk("clean_m_beats", m_beats, 256);
    chk("clean_idx_errs", idx_errs, 0);
    chk("clean_m_sops", m_sops, 1);
    chk("clean_m_eops", m_eops, 1);
    chk("clean_eop_idx", eop_idx, 255);
    chk("clean_frames", frames_done, 1);
    chk("clean_busy_end", busy, 0);
    chk("clean_no_spur", err_cnt[ERR_SPUR], 0);

    // Gap at sample 100
    clr_mon();
    send_beats(0, 100, 1, 0);
    tick();
    chk("gap_err", err, 4'b0010);
    chk("gap_busy", busy, 0);
    chk("gap_core_valid", core_valid, 0);
    repeat (5) tick();
    chk("gap_core_beats", core_beats, 100);
    chk("gap_last_re", 32'(last_re), 99);
    chk("gap_err_cnt", err_cnt[ERR_GAP], 1);

    // Restart at sample 50 with inv=1
    clr_mon();
    send_beats(0, 50, 1, 0);
    send_beats(0, 1, 1, 1);
    chk("rst_err_restart", err, 4'b0001);
    chk("restart_core_inv", core_inv, 1);
    send_beats(1, N - 1, 0, 1);
    chk("restart_wait_busy", busy, 1);
    core_out(4);
    chk("restart_core_beats", core_beats, 306);
    chk("restart_core_sops", core_sops, 2);
    chk("restart_m_beats", m_beats, 256);
    chk("restart_m_eops", m_eops, 1);
    chk("restart_frames", frames_done, 2);
    chk("restart_err_cnt", err_cnt[ERR_RESTART], 1);
    chk("restart_no_gap", err_cnt[ERR_GAP], 0);

    // Spurious core sop while idle
    core_sop_out = 1'b1;
    tick();
    core_sop_out = 1'b0;
    chk("spur_err", err, 4'b0100);
    chk("spur_busy", busy, 0);

`ifdef FFT_SCHED_WDOG_EN
    send_beats(0, N, 1, 0);
    k = 0;
    for (int j = 1; j <= 100; j++) begin
      tick();
      if (err[ERR_TMO]) begin
        k = j;
        break;
      end
    end
    chk("tmo_cycle", k, 64);
    chk("tmo_err", err, 4'b1000);
    chk("tmo_busy", busy, 0);
`else
    clr_mon();
    send_beats(0, N, 1, 0);
    repeat (100) tick();
    k = int'(busy);
    chk("nowdog_busy", k, 1);
    chk("nowdog_no_tmo", err_cnt[ERR_TMO], 0);
    core_out(0);
    chk("nowdog_frames", frames_done, 3);
`endif

    // Reset asserted at LOAD sample 128
    send_beats(0, 128, 1, 1);
    s_valid = 1'b1; s_sop = 1'b0; s_re = 16'sd128; s_im = -16'sd128;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_core_valid", core_valid, 0);
    chk("mid_rst_core_inv", core_inv, 0);
    chk("mid_rst_core_re", 32'(core_re), 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_frames", frames_done, 0);
    chk("mid_rst_err", err, 0);
    s_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_s_ready", s_ready, 1);

    // Fresh frame after reset
    clr_mon();
    send_beats(0, N, 1, 0);
    core_out(3);
    chk("fresh_frames", frames_done, 1);
    chk("fresh_m_beats", m_beats, 256);
    chk("fresh_eop_idx", eop_idx, 255);
    chk("fresh_errs", err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
